// File: rtl/iter_alu_top_if.sv
// Load/compute/done handshake bundle for iter_alu_top: command and operands in,
// ready/state/result/done out.
interface iter_alu_top_if #(
    parameter int WIDTH = 4
);
    logic                 in_load;
    logic [1:0]           in_mode;
    logic [WIDTH-1:0]     in_d1_in;
    logic [WIDTH-1:0]     in_d2_in;
    logic                 out_start;
    logic [1:0]           out_state_main;
    logic [2*WIDTH-1:0]   out_d_out;
    logic                 out_done;

    modport master (
        output in_load, in_mode, in_d1_in, in_d2_in,
        input  out_start, out_state_main, out_d_out, out_done
    );

    modport slave (
        input  in_load, in_mode, in_d1_in, in_d2_in,
        output out_start, out_state_main, out_d_out, out_done
    );
endinterface

// File: rtl/iter_alu_top.sv
// Load/compute/done ALU engine: add, subtract, unsigned max and (when ITER_ALU_MUL_EN
// is defined) iterative shift-add multiply; without it, mode 10 executes as add.
module iter_alu_top #(
    parameter int WIDTH = 4
) (
    input  logic          in_clk,
    input  logic          in_restart_n,
    iter_alu_top_if.slave bus
);
    localparam int RW = 2 * WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_CALC = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    localparam logic [1:0] MODE_ADD = 2'b00;
    localparam logic [1:0] MODE_SUB = 2'b01;
    localparam logic [1:0] MODE_MUL = 2'b10;
    localparam logic [1:0] MODE_MAX = 2'b11;

    state_t            state_r;
    state_t            state_s;
    logic [WIDTH-1:0]  a_r;
    logic [WIDTH-1:0]  b_r;
    logic [1:0]        mode_r;
    logic [RW-1:0]     d_out_r;
    logic [RW-1:0]     result_s;
    logic [RW-1:0]     a_ext_s;
    logic [RW-1:0]     b_ext_s;
    logic              calc_last_s;

    assign a_ext_s = {{WIDTH{1'b0}}, a_r};
    assign b_ext_s = {{WIDTH{1'b0}}, b_r};

`ifdef ITER_ALU_MUL_EN
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1'b1);

    logic [CW-1:0]     cnt_r;
    logic [RW-1:0]     acc_r;
    logic [RW-1:0]     mcand_r;
    logic [WIDTH-1:0]  mplier_r;
    logic [RW-1:0]     acc_next_s;

    // One shift-add step: add the shifted multiplicand when the multiplier LSB is set.
    always_comb begin
        acc_next_s = acc_r;
        if (mplier_r[0]) begin
            acc_next_s = acc_r + mcand_r;
        end else begin
            acc_next_s = acc_r;
        end
    end

    // Multiply stays in CALC until the step counter has run down to zero.
    always_comb begin
        calc_last_s = 1'b1;
        if ((mode_r == MODE_MUL) && (cnt_r != {CW{1'b0}})) begin
            calc_last_s = 1'b0;
        end else begin
            calc_last_s = 1'b1;
        end
    end

    // Multiplier datapath: seeded on the LOAD edge, stepped once per CALC edge.
    always_ff @(posedge in_clk or negedge in_restart_n) begin
        if (!in_restart_n) begin
            cnt_r    <= {CW{1'b0}};
            acc_r    <= {RW{1'b0}};
            mcand_r  <= {RW{1'b0}};
            mplier_r <= {WIDTH{1'b0}};
        end else if (state_r == ST_LOAD) begin
            cnt_r    <= (bus.in_mode == MODE_MUL) ? CNT_MAX : {CW{1'b0}};
            acc_r    <= {RW{1'b0}};
            mcand_r  <= {{WIDTH{1'b0}}, bus.in_d1_in};
            mplier_r <= bus.in_d2_in;
        end else if ((state_r == ST_CALC) && (mode_r == MODE_MUL)) begin
            acc_r    <= acc_next_s;
            mcand_r  <= {mcand_r[RW-2:0], 1'b0};
            mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
            if (cnt_r != {CW{1'b0}}) begin
                cnt_r <= cnt_r - CNT_ONE;
            end
        end
    end
`else
    assign calc_last_s = 1'b1;
`endif

    // Result selection for the current operation.
    always_comb begin
        result_s = {RW{1'b0}};
        case (mode_r)
            MODE_ADD: result_s = a_ext_s + b_ext_s;
            MODE_SUB: result_s = a_ext_s - b_ext_s;
`ifdef ITER_ALU_MUL_EN
            MODE_MUL: result_s = acc_next_s;
`else
            MODE_MUL: result_s = a_ext_s + b_ext_s;
`endif
            MODE_MAX: result_s = (b_r > a_r) ? b_ext_s : a_ext_s;
            default:  result_s = {RW{1'b0}};
        endcase
    end

    // Main FSM next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.in_load) begin
                    state_s = ST_LOAD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD: state_s = ST_CALC;
            ST_CALC: begin
                if (calc_last_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_CALC;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Main FSM state register.
    always_ff @(posedge in_clk or negedge in_restart_n) begin
        if (!in_restart_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Operand/mode capture on the LOAD edge and result write on the final CALC edge.
    always_ff @(posedge in_clk or negedge in_restart_n) begin
        if (!in_restart_n) begin
            a_r     <= {WIDTH{1'b0}};
            b_r     <= {WIDTH{1'b0}};
            mode_r  <= 2'b00;
            d_out_r <= {RW{1'b0}};
        end else begin
            if (state_r == ST_LOAD) begin
                a_r    <= bus.in_d1_in;
                b_r    <= bus.in_d2_in;
                mode_r <= bus.in_mode;
            end
            if ((state_r == ST_CALC) && calc_last_s) begin
                d_out_r <= result_s;
            end
        end
    end

    assign bus.out_start      = (state_r == ST_IDLE);
    assign bus.out_state_main = state_r;
    assign bus.out_d_out      = d_out_r;
    assign bus.out_done       = (state_r == ST_DONE);
endmodule

// File: tb/tb_iter_alu_top.sv
// Scoreboard bench for iter_alu_top (WIDTH=4): stimulus pushes hand-computed results,
// a negedge monitor pops them on each done pulse.
module tb_iter_alu_top;
    logic clk;
    logic rst_n;
    int   pass_cnt;
    int   total_cnt;
    logic [7:0] sb[$];
    logic [7:0] last_dout;
    logic       prev_done;

`ifdef ITER_ALU_MUL_EN
    localparam int         MUL_CYC = 4;
    localparam logic [7:0] EXP_M_FF = 8'hE1;
    localparam logic [7:0] EXP_M_35 = 8'h0F;
    localparam logic [7:0] EXP_M_09 = 8'h00;
`else
    localparam int         MUL_CYC = 1;
    localparam logic [7:0] EXP_M_FF = 8'h1E;
    localparam logic [7:0] EXP_M_35 = 8'h08;
    localparam logic [7:0] EXP_M_09 = 8'h09;
`endif

    iter_alu_top_if #(.WIDTH(4)) bus ();

    iter_alu_top #(.WIDTH(4)) dut (
        .in_clk       (clk),
        .in_restart_n (rst_n),
        .bus          (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pop and compare on every done pulse, and require the result to hold otherwise.
    always @(negedge clk) begin
        if (!rst_n) begin
            last_dout = 8'h00;
            prev_done = 1'b0;
        end else begin
            if (bus.out_done) begin
                check("done_single_cycle", 32'(prev_done), 32'd0);
                check("sb_pending", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    check("result", 32'(bus.out_d_out), 32'(sb.pop_front()));
                end
                last_dout = bus.out_d_out;
            end else begin
                check("dout_hold", 32'(bus.out_d_out), 32'(last_dout));
            end
            prev_done = bus.out_done;
        end
    end

    task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic [1:0] mode,
                          input logic [7:0] exp, input int calc_exp, input bit poke,
                          input string name);
        int n;
        bus.in_load = 1'b1;
        sb.push_back(exp);
        @(posedge clk); #1;
        check({name, "_load_state"}, 32'(bus.out_state_main), 32'd1);
        bus.in_load  = 1'b0;
        bus.in_d1_in = a;
        bus.in_d2_in = b;
        bus.in_mode  = mode;
        @(posedge clk); #1;
        n = 0;
        while (bus.out_state_main == 2'b10 && n < 20) begin
            n++;
            bus.in_d1_in = ~a;
            bus.in_d2_in = ~b;
            bus.in_mode  = ~mode;
            if (poke) bus.in_load = 1'b1;
            @(posedge clk); #1;
        end
        check({name, "_calc_cycles"}, 32'(n), 32'(calc_exp));
        check({name, "_done_state"}, 32'(bus.out_state_main), 32'd3);
        bus.in_load = poke;
        @(posedge clk); #1;
        bus.in_load = 1'b0;
        check({name, "_idle_state"}, 32'(bus.out_state_main), 32'd0);
        check({name, "_start"}, 32'(bus.out_start), 32'd1);
        if (poke) begin
            repeat (2) @(posedge clk);
            #1;
            check({name, "_poke_ignored"}, 32'(bus.out_state_main), 32'd0);
        end
    endtask

    initial begin
        int n;
        int j;
        int last;
        logic [3:0] h_a[3];
        logic [3:0] h_b[3];
        logic [1:0] h_m[3];
        logic [7:0] h_e[3];
        h_a[0] = 4'd5; h_b[0] = 4'd6; h_m[0] = 2'b00; h_e[0] = 8'h0B;
        h_a[1] = 4'd1; h_b[1] = 4'd3; h_m[1] = 2'b01; h_e[1] = 8'hFE;
        h_a[2] = 4'd8; h_b[2] = 4'd3; h_m[2] = 2'b11; h_e[2] = 8'h08;

        pass_cnt = 0;
        total_cnt = 0;
        rst_n = 1'b0;
        bus.in_load = 1'b0;
        bus.in_mode = 2'b00;
        bus.in_d1_in = 4'h0;
        bus.in_d2_in = 4'h0;
        #12;
        check("rst_state", 32'(bus.out_state_main), 32'd0);
        check("rst_dout", 32'(bus.out_d_out), 32'd0);
        check("rst_done", 32'(bus.out_done), 32'd0);
        check("rst_start", 32'(bus.out_start), 32'd1);
        @(negedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(4'd3,  4'd1,  2'b00, 8'h04,    1,       1'b0, "add_3_1");
        run_op(4'd2,  4'd4,  2'b01, 8'hFE,    1,       1'b0, "sub_2_4");
        run_op(4'd9,  4'd12, 2'b11, 8'h0C,    1,       1'b0, "max_9_12");
        run_op(4'd7,  4'd7,  2'b11, 8'h07,    1,       1'b0, "max_7_7");
        run_op(4'd15, 4'd15, 2'b10, EXP_M_FF, MUL_CYC, 1'b0, "mul_15_15");
        run_op(4'd15, 4'd1,  2'b00, 8'h10,    1,       1'b0, "add_carry");
        run_op(4'd5,  4'd5,  2'b01, 8'h00,    1,       1'b0, "sub_zero");
        run_op(4'd15, 4'd0,  2'b11, 8'h0F,    1,       1'b0, "max_15_0");
        run_op(4'd3,  4'd5,  2'b10, EXP_M_35, MUL_CYC, 1'b1, "mul_3_5_poke");
        run_op(4'd0,  4'd9,  2'b10, EXP_M_09, MUL_CYC, 1'b0, "mul_0_9");
        run_op(4'd12, 4'd3,  2'b01, 8'h09,    1,       1'b1, "sub_12_3_poke");

        // Reset in the middle of a multiply: no result, no done pulse afterwards.
        bus.in_load = 1'b1;
        @(posedge clk); #1;
        bus.in_load  = 1'b0;
        bus.in_d1_in = 4'd15;
        bus.in_d2_in = 4'd15;
        bus.in_mode  = 2'b10;
        @(posedge clk); #1;
`ifdef ITER_ALU_MUL_EN
        @(posedge clk); #1;
`endif
        check("midcalc_in_calc", 32'(bus.out_state_main), 32'd2);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("midcalc_rst_state", 32'(bus.out_state_main), 32'd0);
        check("midcalc_rst_dout", 32'(bus.out_d_out), 32'd0);
        check("midcalc_rst_done", 32'(bus.out_done), 32'd0);
        check("midcalc_rst_start", 32'(bus.out_start), 32'd1);
        sb.delete();
        @(negedge clk); #2;
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("post_rst_idle", 32'(bus.out_state_main), 32'd0);
        check("post_rst_start", 32'(bus.out_start), 32'd1);

        // Load held high with operands changing every cycle.
        bus.in_load = 1'b1;
        j = 0;
        n = 0;
        last = 0;
        while (j < 3 && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (bus.out_state_main == 2'b01) begin
                if (j > 0) check("held_throughput", 32'(n - last), 32'd4);
                last = n;
                bus.in_d1_in = h_a[j];
                bus.in_d2_in = h_b[j];
                bus.in_mode  = h_m[j];
                sb.push_back(h_e[j]);
                j++;
            end else begin
                bus.in_d1_in = 4'(n) ^ 4'hA;
                bus.in_d2_in = 4'(n) ^ 4'h5;
                bus.in_mode  = 2'b10;
            end
        end
        check("held_load_count", 32'(j), 32'd3);
        @(posedge clk); #1;
        bus.in_load  = 1'b0;
        bus.in_d1_in = 4'hF;
        bus.in_d2_in = 4'hF;
        n = 0;
        while (bus.out_state_main != 2'b00 && n < 20) begin
            n++;
            @(posedge clk); #1;
        end
        repeat (3) @(posedge clk);
        #1;
        check("held_final_idle", 32'(bus.out_state_main), 32'd0);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/iter_alu_top.md
# iter_alu_top

Parametrised single-clock successor to the two-phase FSM/datapath top of the Sudoku project. It accepts a load command, captures two WIDTH-bit operands and an operation mode in the following cycle, and computes the result in a datapath. The datapath finishes single-cycle operations in one cycle and runs multiply as an iterative shift-add. A registered result and a one-cycle done pulse follow. The block is the template for solver sub-engines that need a load/compute/done handshake with a visible main-state encoding.

## Interface
- WIDTH, 4: operand width in bits (≥2); the result is 2*WIDTH bits.
- in_clk  input  1  single clock; all state changes on the rising edge.
- in_restart_n  input  1  asynchronous, active-low reset.
- in_load  input  1  command: start a new operation (sampled only in IDLE).
- in_mode  input  2  operation: 00 add, 01 subtract, 10 multiply, 11 unsigned max (captured in LOAD).
- in_d1_in  input  WIDTH  operand A (captured in LOAD).
- in_d2_in  input  WIDTH  operand B (captured in LOAD).
- out_start  output  1  high while in IDLE (ready for in_load).
- out_state_main  output  2  main FSM state: 00 IDLE, 01 LOAD, 10 CALC, 11 DONE.
- out_d_out  output  2*WIDTH  last completed result; held until the next DONE.
- out_done  output  1  high for exactly the DONE cycle.

## Operation
- Reset (in_restart_n low, any time, including mid-CALC): state goes to IDLE immediately.
  - out_state_main=00, out_d_out=0, out_done=0, internal operand, mode and counter registers=0.
  - out_start is 1 while reset is asserted and after it is released.
- IDLE: in_load=1 at an edge moves to LOAD; otherwise stay in IDLE.
- LOAD: one cycle.
  - The exiting edge captures in_d1_in, in_d2_in and in_mode.
  - It loads the step counter with WIDTH-1 for multiply and 0 for all other modes.
  - It clears the multiply accumulator and moves to CALC.
- CALC: for multiply, each edge performs one shift-add step.
  - If the multiplier LSB is 1, the shifted multiplicand is added to the accumulator.
  - The multiplicand then shifts left one bit, the multiplier shifts right one bit, and the counter decrements.
  - At the edge where the counter is 0, the final value is written to out_d_out and the state moves to DONE.
- DONE: one cycle with out_done=1, then return to IDLE unconditionally.
- in_load is ignored in LOAD, CALC and DONE. A load held high is taken again on the first IDLE edge.
- Arithmetic, all results 2*WIDTH bits:
  - Add: zero-extended A+B; the carry lands in bit WIDTH.
  - Subtract: A−B modulo 2^(2*WIDTH), so a negative result is two's-complement sign-extended.
  - Multiply: unsigned A*B.
  - Max: zero-extended unsigned max(A,B); if A=B the result is A.
- Input changes outside the LOAD cycle have no effect on an operation already in progress.

## Timing
- Load sampled high at edge k:
  - k: IDLE→LOAD.
  - k+1: operands captured, LOAD→CALC.
  - Non-multiply, k+2: result registered, CALC→DONE; out_done high from k+2 to k+3; IDLE at k+3.
  - Multiply: CALC lasts WIDTH cycles; result and DONE at edge k+1+WIDTH; IDLE at k+2+WIDTH.
- Throughput with in_load held high:
  - 4 cycles per operation for non-multiply (IDLE, LOAD, CALC, DONE).
  - WIDTH+3 cycles per multiply.
- out_d_out changes only on the CALC→DONE edge or on reset.
- All outputs are registered or decoded from the state register only. There is no combinational path from inputs to outputs.

## Configuration
- ITER_ALU_MUL_EN defined:
  - Multiply hardware (accumulator, shift registers, WIDTH-step counter) is present.
  - Mode 10 behaves as described above.
- ITER_ALU_MUL_EN undefined:
  - No multiply hardware is built.
  - Mode 10 is executed as add with the single-cycle CALC timing.
  - All other behaviour is unchanged.

## Test plan
Benches use WIDTH=4 and ITER_ALU_MUL_EN defined unless stated.
- Reset, then in_load pulse, then A=3, B=1, mode=00 in the LOAD cycle -> states 00→01→10→11→00; out_d_out=0x04 with out_done=1 for one cycle, exactly 2 edges after the LOAD edge.
- A=2, B=4, mode=01 -> out_d_out=0xFE; A=9, B=12, mode=11 -> out_d_out=0x0C; A=B=7, mode=11 -> out_d_out=0x07.
- A=15, B=15, mode=10 -> CALC for exactly 4 cycles, out_d_out=0xE1. Rebuilt without ITER_ALU_MUL_EN -> 1 CALC cycle, out_d_out=0x1E.
- Reset asserted in the 2nd CALC cycle of a multiply -> out_state_main=00, out_d_out=0, out_done=0 immediately; after release, out_start=1 and no done pulse is produced.
- in_load held high with operands changing every cycle -> only operands present in each LOAD cycle affect results; non-multiply ops complete one every 4 cycles; out_d_out is stable between done pulses.
- in_load pulsed during CALC and DONE -> ignored; the state returns to IDLE and waits for a new load.
